// File: rtl/mem_access_ctrl.sv
// MEM-stage memory access sequencer.
// Issues one req/ack transaction per load/store and stalls the front of the
// pipeline while it is outstanding. Also flags misaligned accesses, raises a
// sticky error when the memory never answers, and keeps a saturating count
// of stall cycles.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | no transaction; an aligned access stalls and issues next edge
//   BUSY   | request outstanding; wait for ack or timeout
//   DONE   | one free cycle so the finished instruction leaves EX/MEM
module mem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             MemtoRegM,
  input  logic             MemWriteM,
  input  logic [31:0]      ALUOutM,
  input  logic [31:0]      WriteDataM,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [31:0]      ReadDataM,
  output logic             StallM,
  output logic             FlushW,
  output logic             MisalignM,
  output logic             TimeoutErr,
  output logic [CNT_W-1:0] StallCnt
);

  // Timeout counter only has to reach TIMEOUT-1, so size it for that value.
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_req;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_terr;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [TO_W-1:0]   r_to_cnt;

  logic              w_acc;
  logic              w_unaligned;
  logic              w_stall;
  logic              w_misalign;
  logic              w_issue;
  logic              w_complete;
  logic              w_expire;

  assign w_acc       = MemtoRegM | MemWriteM;
  assign w_unaligned = |ALUOutM[1:0];

  // Next-state and per-cycle control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_misalign  = 1'b0;
    w_issue     = 1'b0;
    w_complete  = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (w_unaligned) begin
            w_misalign = 1'b1;
          end else begin
            w_stall     = 1'b1;
            w_issue     = 1'b1;
            w_state_nxt = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        // A late ack wins over an expiring timer.
        if (mem_ack) begin
          w_complete  = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_to_cnt == TO_LAST) begin
          w_expire    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request interface: captured on issue, held through BUSY, req dropped on exit.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else if (w_issue) begin
      r_req   <= 1'b1;
      r_we    <= MemWriteM;
      r_addr  <= {ALUOutM[31:2], 2'b00};
      r_wdata <= WriteDataM;
    end else if (w_complete || w_expire) begin
      r_req   <= 1'b0;
    end
  end

  // BUSY-cycle timer, restarted on every issue.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_to_cnt <= '0;
    end else if (w_issue) begin
      r_to_cnt <= '0;
    end else if (r_state == S_BUSY && !mem_ack && r_to_cnt != TO_LAST) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // Load data capture; an aborted transaction returns zero.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_rdata <= 32'd0;
    end else if (w_complete && !r_we) begin
      r_rdata <= mem_rdata;
    end else if (w_expire) begin
      r_rdata <= 32'd0;
    end
  end

  // Sticky timeout flag.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_terr <= 1'b0;
    end else if (w_expire) begin
      r_terr <= 1'b1;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && r_stall_cnt != {CNT_W{1'b1}}) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign mem_req    = r_req;
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign ReadDataM  = r_rdata;
  assign TimeoutErr = r_terr;
  assign StallCnt   = r_stall_cnt;
  assign StallM     = w_stall;
  assign FlushW     = w_stall;
  assign MisalignM  = w_misalign;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all shadowed by a transaction-level model that is
// compared against every output on every falling edge.
module tb_mem_access_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             rst = 1'b0;
  logic             MemtoRegM = 1'b0;
  logic             MemWriteM = 1'b0;
  logic [31:0]      ALUOutM = 32'd0;
  logic [31:0]      WriteDataM = 32'd0;
  logic             mem_ack = 1'b0;
  logic [31:0]      mem_rdata = 32'd0;
  logic             mem_req;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      ReadDataM;
  logic             StallM;
  logic             FlushW;
  logic             MisalignM;
  logic             TimeoutErr;
  logic [CNT_W-1:0] StallCnt;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .rst(rst),
    .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .ReadDataM(ReadDataM), .StallM(StallM), .FlushW(FlushW), .MisalignM(MisalignM),
    .TimeoutErr(TimeoutErr), .StallCnt(StallCnt)
  );

  always #5 CLK = ~CLK;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // m_busy: a request is outstanding; m_waited: BUSY cycles already spent
  // without an answer; m_cool: the single free cycle after a transaction.
  bit          m_busy = 0;
  bit          m_cool = 0;
  int          m_waited = 0;
  bit          m_we = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
  bit          m_terr = 0;
  int          m_cnt = 0;

  initial begin
    forever begin
      bit acc, aligned, free, e_stall, e_mis;
      @(negedge CLK);
      if (!rst) begin
        m_busy = 0; m_cool = 0; m_waited = 0; m_we = 0;
        m_addr = 0; m_wdata = 0; m_rdata = 0; m_terr = 0; m_cnt = 0;
      end
      acc     = MemtoRegM | MemWriteM;
      aligned = (ALUOutM[1:0] == 2'b00);
      free    = !m_busy && !m_cool;
      e_stall = m_busy || (free && acc && aligned);
      e_mis   = free && acc && !aligned;

      cmp("mem_req",    32'(mem_req),    32'(m_busy));
      cmp("mem_we",     32'(mem_we),     32'(m_we));
      cmp("mem_addr",   mem_addr,        m_addr);
      cmp("mem_wdata",  mem_wdata,       m_wdata);
      cmp("ReadDataM",  ReadDataM,       m_rdata);
      cmp("StallM",     32'(StallM),     32'(e_stall));
      cmp("FlushW",     32'(FlushW),     32'(e_stall));
      cmp("MisalignM",  32'(MisalignM),  32'(e_mis));
      cmp("TimeoutErr", 32'(TimeoutErr), 32'(m_terr));
      cmp("StallCnt",   32'(StallCnt),   32'(m_cnt));

      // What the coming rising edge does.
      if (rst) begin
        if (e_stall && m_cnt < CNT_MAX) m_cnt++;
        if (m_busy) begin
          if (mem_ack) begin
            m_busy = 0; m_cool = 1;
            if (!m_we) m_rdata = mem_rdata;
          end else if (m_waited + 1 == TIMEOUT) begin
            m_busy = 0; m_cool = 1; m_terr = 1; m_rdata = 0;
          end else begin
            m_waited++;
          end
        end else if (m_cool) begin
          m_cool = 0;
        end else if (acc && aligned) begin
          m_busy = 1; m_waited = 0; m_we = MemWriteM;
          m_addr = {ALUOutM[31:2], 2'b00}; m_wdata = WriteDataM;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic idle_inputs();
    MemtoRegM = 0; MemWriteM = 0; ALUOutM = 0; WriteDataM = 0; mem_ack = 0;
  endtask

  // Runs one access from IDLE; lat is the 0-based BUSY cycle that acks (-1 = never).
  // Returns in the DONE cycle with inputs idle.
  task automatic do_acc(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int lat,
                        output int stall_n, output int req_n);
    int k;
    k = 0; stall_n = 0; req_n = 0;
    MemtoRegM = !wr; MemWriteM = wr; ALUOutM = addr; WriteDataM = wd;
    mem_rdata = rd; mem_ack = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK);
      if (StallM) stall_n++;
      if (mem_req) req_n++;
      step();
      if (!mem_req && req_n > 0) begin
        idle_inputs();
        break;
      end
      mem_ack = (mem_req && k == lat);
      if (mem_req) k++;
    end
    idle_inputs();
  endtask

  initial begin
    int sn, rn;
    bit [4:0] pat;
    bit req_seen;
    int lat, k, r;
    logic [31:0] a;

    idle_inputs();
    rst = 0;
    repeat (2) @(posedge CLK);
    #1;
    cmp("rst mem_req", 32'(mem_req), 32'd0);
    cmp("rst StallCnt", 32'(StallCnt), 32'd0);
    cmp("rst ReadDataM", ReadDataM, 32'd0);
    rst = 1;
    step();

    // Aligned load, ack in first BUSY cycle.
    do_acc(0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0, sn, rn);
    cmp("ld stall cycles", 32'(sn), 32'd2);
    cmp("ld req cycles", 32'(rn), 32'd1);
    cmp("ld ReadDataM", ReadDataM, 32'hDEAD_BEEF);
    cmp("ld StallCnt", 32'(StallCnt), 32'd2);
    cmp("ld mem_addr", mem_addr, 32'h10);
    cmp("ld mem_we", 32'(mem_we), 32'd0);
    step();

    // Store acked in third BUSY cycle.
    do_acc(1, 32'h0000_0020, 32'h1234_5678, 32'hFFFF_FFFF, 2, sn, rn);
    cmp("st stall cycles", 32'(sn), 32'd4);
    cmp("st req cycles", 32'(rn), 32'd3);
    cmp("st mem_we", 32'(mem_we), 32'd1);
    cmp("st mem_wdata", mem_wdata, 32'h1234_5678);
    cmp("st ReadDataM kept", ReadDataM, 32'hDEAD_BEEF);
    cmp("st StallCnt", 32'(StallCnt), 32'd6);
    step();

    // Misaligned load.
    MemtoRegM = 1; ALUOutM = 32'h13;
    @(negedge CLK);
    cmp("mis MisalignM", 32'(MisalignM), 32'd1);
    cmp("mis StallM", 32'(StallM), 32'd0);
    step();
    cmp("mis mem_req", 32'(mem_req), 32'd0);
    idle_inputs();
    #1;
    cmp("mis flag clears", 32'(MisalignM), 32'd0);
    cmp("mis ReadDataM kept", ReadDataM, 32'hDEAD_BEEF);

    // Back-to-back loads.
    MemtoRegM = 1; ALUOutM = 32'h100; mem_rdata = 32'h1111_2222;
    @(negedge CLK); pat[0] = StallM;
    step(); mem_ack = mem_req;
    @(negedge CLK); pat[1] = StallM;
    step(); mem_ack = 0; ALUOutM = 32'h200; mem_rdata = 32'hCAFE_F00D;
    @(negedge CLK); pat[2] = StallM;
    step();
    @(negedge CLK); pat[3] = StallM;
    step(); mem_ack = mem_req;
    @(negedge CLK); pat[4] = StallM;
    step(); idle_inputs();
    cmp("b2b stall pattern", 32'(pat), 32'b11011);
    cmp("b2b mem_addr", mem_addr, 32'h200);
    cmp("b2b ReadDataM", ReadDataM, 32'hCAFE_F00D);
    cmp("b2b StallCnt", 32'(StallCnt), 32'd10);
    step();

    // No ack: timeout.
    do_acc(0, 32'h40, 32'h0, 32'h7777_7777, -1, sn, rn);
    cmp("to stall cycles", 32'(sn), 32'(TIMEOUT + 1));
    cmp("to req cycles", 32'(rn), 32'(TIMEOUT));
    cmp("to TimeoutErr", 32'(TimeoutErr), 32'd1);
    cmp("to ReadDataM", ReadDataM, 32'd0);
    cmp("to StallCnt", 32'(StallCnt), 32'd27);
    step();

    do_acc(0, 32'h44, 32'h0, 32'h0BAD_F00D, 0, sn, rn);
    cmp("sticky TimeoutErr", 32'(TimeoutErr), 32'd1);
    cmp("sticky ReadDataM", ReadDataM, 32'h0BAD_F00D);
    cmp("sticky StallCnt", 32'(StallCnt), 32'd29);
    step();

    // Reset in the second BUSY cycle.
    MemtoRegM = 1; ALUOutM = 32'h300;
    step(); step();
    idle_inputs(); rst = 0; #1;
    cmp("mid-rst mem_req", 32'(mem_req), 32'd0);
    cmp("mid-rst StallM", 32'(StallM), 32'd0);
    cmp("mid-rst StallCnt", 32'(StallCnt), 32'd0);
    cmp("mid-rst TimeoutErr", 32'(TimeoutErr), 32'd0);
    step(); rst = 1;
    step();
    do_acc(0, 32'h304, 32'h0, 32'h5A5A_A5A5, 0, sn, rn);
    cmp("post-rst stall cycles", 32'(sn), 32'd2);
    cmp("post-rst ReadDataM", ReadDataM, 32'h5A5A_A5A5);
    step();

    // Randomized traffic with random memory latency.
    req_seen = 0; lat = 0; k = 0;
    for (int c = 0; c < 4000; c++) begin
      step();
      rst = ($urandom_range(0, 599) != 0);
      if (mem_req) begin
        if (!req_seen) begin
          req_seen = 1; k = 0; lat = $urandom_range(0, TIMEOUT + 1);
        end else begin
          k++;
        end
        mem_ack = (k == lat);
      end else begin
        req_seen = 0;
        mem_ack = ($urandom_range(0, 9) == 0);
      end
      mem_rdata = $urandom;
      r = $urandom_range(0, 9);
      MemtoRegM = (r >= 4 && r <= 6) || r == 9;
      MemWriteM = (r >= 7);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      ALUOutM = a;
      WriteDataM = $urandom;
    end
    rst = 1;
    idle_inputs();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
